hssim_fuse: RTL and testbench
=============================

Name: hssim_fuse

Overview:
- Consumer stage directly downstream of the HSSIM decision unit.
- Carries raw old and new frame pixel beats through a delay line matched to HSSIM latency.
- Selects old or new pixels per pixel using the HSSIM `del` map (0 or 255).
- Emits the fused frame as a valid/ready stream with end-of-frame marking, and generates the shared `stall` that freezes HSSIM and upstream.

Parameters:
- PIXELS_PER_BEAT, 16: pixels per beat, 8 bits each.
- IMAGE_DIM, 512: frame is IMAGE_DIM x IMAGE_DIM pixels.
- HSSIM_LATENCY, 10: enabled (non-stalled) cycles from map beat accepted by HSSIM to matching `del` beat; integrator sets this to the HSSIM pipeline depth.
- DATA_WIDTH, 8*PIXELS_PER_BEAT: beat width in bits.

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- s_valid  in  1  input beat valid; old/new pixels and the HSSIM maps advance together.
- s_ready  out  1  equals ~stall.
- s_old_pix  in  DATA_WIDTH  old-frame pixels.
- s_new_pix  in  DATA_WIDTH  new-frame pixels.
- del  in  DATA_WIDTH  HSSIM decision, one byte per pixel.
- stall  out  1  freeze for HSSIM and upstream pipelines.
- m_data  out  DATA_WIDTH  fused pixels.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  high on the final beat of a frame.
- frame_done  out  1  one-cycle pulse when the last beat handshakes.

Behaviour:
- Reset (aresetn=0 at posedge):
  - m_valid=0, m_last=0, frame_done=0, m_data=0.
  - Delay-line valid bits cleared; beat counter=0; skid buffer empty.
  - stall=0, so s_ready=1 during and after reset.
  - Pixel delay-line data is not reset.
- Delay line:
  - HSSIM_LATENCY stages of {valid, old, new}.
  - Advances only when stall=0.
  - Stage 0 captures {s_valid, s_old_pix, s_new_pix}.
  - A stage with valid=0 is a bubble and produces no output.
- Select:
  - Combinational at the last stage, per pixel j: fused[j] = (del[j*8+:8]==8'd255) ? new[j] : old[j].
  - Any `del` byte other than 255, including illegal values, selects old.
- Output:
  - Fused beat registered into a 2-entry skid buffer.
  - Capture happens on the non-stalled cycle in which the last stage is valid.
  - Latency from s_valid&s_ready to m_valid is HSSIM_LATENCY+1 cycles when never stalled.
- Stall:
  - stall = (skid occupancy==2) | (occupancy==1 & m_valid & ~m_ready & last stage valid).
  - Registered, so it is a glitch-free function of state.
  - The skid buffer never overflows and never drops a beat.
  - While m_valid=1 & m_ready=0, m_data and m_last hold stable.
- Beat counter:
  - Counts output handshakes from 0 to BEATS_PER_FRAME-1, where BEATS_PER_FRAME = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT (16384 at defaults).
  - m_last=1 when the presented beat index equals BEATS_PER_FRAME-1.
  - On that handshake: frame_done pulses the next cycle and the counter wraps to 0.
- Simultaneous push and pop in one cycle: occupancy unchanged, FIFO order preserved.
- Reset mid-frame: all in-flight beats discarded; the next accepted beat is beat 0 of a new frame.

Optional Feature:
- Macro: HSSIM_FUSE_STATS_EN.
- When defined:
  - Adds output port new_count (width clog2(IMAGE_DIM*IMAGE_DIM)+1).
  - An internal accumulator adds popcount(del byte==255) for each output beat on handshake.
  - On the last beat, new_count latches the frame total; the accumulator restarts from 0.
  - new_count resets to 0.
- When undefined: the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package lrf_pkg: PIXELS_PER_BEAT-derived DATA_WIDTH, BEATS_PER_FRAME constant function, DEL_SELECT_NEW=8'd255.
- One sub-module, lrf_skid_buf: 2-entry valid/ready skid buffer with occupancy output, parameterised width of DATA_WIDTH+1 to carry m_last.

Test Plan:
- Reset, then HSSIM_LATENCY=10, continuous s_valid with m_ready=1 and del all 255 -> first m_valid 11 cycles after first accept; m_data equals new pixels, in order.
- Alternating del bytes 0x00/0xFF/0x7F -> pixels 0 and 2 old, pixel 1 new; 0x7F selects old.
- m_ready low for 20 cycles mid-stream -> stall asserts within 2 output beats; no beat lost or duplicated; m_data stable while held.
- s_valid gaps (1 on, 2 off) -> output beats contiguous in order; bubbles are not counted by the beat counter.
- Full frame at IMAGE_DIM=64, PIXELS_PER_BEAT=16 -> m_last on beat 255 only; frame_done pulses once; the next frame starts at index 0.
- aresetn low for 1 cycle at beat 100 -> outputs cleared; the next frame's m_last comes exactly 256 beats later. With HSSIM_FUSE_STATS_EN and del all 255 -> new_count=4096.

Source files
------------

// File: rtl/lrf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lrf_pkg
//  Purpose  : Shared constants and sizing helpers for the HSSIM fuse stage.
//             - DEL_SELECT_NEW : `del` byte value that selects the new pixel
//             - data_width()   : beat width from pixels per beat
//             - beats_per_frame(): beats in one square frame
//             - idx_width()    : counter width able to hold 0..n-1
//  Revision : 1.0  initial release
// ============================================================================
package lrf_pkg;

    // Any other `del` value, legal or not, keeps the old pixel.
    localparam logic [7:0] DEL_SELECT_NEW = 8'd255;

    function automatic int data_width(input int ppb);
        return 8 * ppb;
    endfunction

    function automatic int beats_per_frame(input int dim, input int ppb);
        return (dim * dim) / ppb;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lrf_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : lrf_skid_buf
//  Purpose  : Two-entry valid/ready skid buffer (FIFO order) with occupancy.
//             Head entry drives the output directly so held data stays
//             stable while the consumer back-pressures.
//  Ports    : clk, aresetn (sync, active-low)
//             i_push / i_din      : write side (ignored when full w/o pop)
//             o_valid / i_ready   : read side handshake
//             o_dout              : head entry
//             o_occ               : current occupancy (0..2)
//  Revision : 1.0  initial release
// ============================================================================
module lrf_skid_buf #(
    parameter int WIDTH = 129
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_dout,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_mem0;   // head
    logic [WIDTH-1:0] r_mem1;   // tail (only meaningful when occupancy is 2)
    logic [1:0]       r_occ;
    logic             w_pop;
    logic             w_push_ok;

    assign w_pop     = (r_occ != 2'd0) && i_ready;
    assign w_push_ok = i_push && ((r_occ != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({w_push_ok, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_mem0 <= i_din;
                    else               r_mem1 <= i_din;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_mem0 <= r_mem1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the incoming beat lands behind
                    // whatever remains after the pop.
                    if (r_occ == 2'd1) begin
                        r_mem0 <= i_din;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = (r_occ != 2'd0);
    assign o_dout  = r_mem0;
    assign o_occ   = r_occ;

endmodule
`default_nettype wire

// File: rtl/hssim_fuse.sv
`default_nettype none
// ============================================================================
//  Module   : hssim_fuse
//  Purpose  : Consumer stage after the HSSIM decision unit. Delays raw old
//             and new pixel beats to line up with the HSSIM `del` map, picks
//             new (del==255) or old per pixel, and streams the fused frame
//             out through a skid buffer with end-of-frame marking. Produces
//             the shared `stall` that freezes HSSIM and upstream.
//  Ports    : clk, aresetn (sync, active-low)
//             s_valid/s_ready, s_old_pix, s_new_pix : input beats
//             del        : HSSIM decision, one byte per pixel
//             stall      : pipeline freeze (s_ready == ~stall)
//             m_data/m_valid/m_ready/m_last : fused output stream
//             frame_done : one-cycle pulse after the last beat handshakes
//             new_count  : per-frame count of new-selected pixels
//                          (only with HSSIM_FUSE_STATS_EN defined)
//  Options  : `define HSSIM_FUSE_STATS_EN to add the new_count statistic.
//  Revision : 1.0  initial release
// ============================================================================
module hssim_fuse
    import lrf_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int HSSIM_LATENCY   = 10,
    parameter int DATA_WIDTH      = data_width(PIXELS_PER_BEAT)
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_old_pix,
    input  logic [DATA_WIDTH-1:0] s_new_pix,
    input  logic [DATA_WIDTH-1:0] del,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  frame_done
`ifdef HSSIM_FUSE_STATS_EN
    ,
    output logic [$clog2(IMAGE_DIM*IMAGE_DIM):0] new_count
`endif
);

    localparam int BEATS_PER_FRAME = beats_per_frame(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int IDX_W           = idx_width(BEATS_PER_FRAME);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS_PER_FRAME - 1);
`ifdef HSSIM_FUSE_STATS_EN
    localparam int PC_W   = $clog2(PIXELS_PER_BEAT + 1);
    localparam int CNT_W  = $clog2(IMAGE_DIM * IMAGE_DIM) + 1;
    localparam int SKID_W = DATA_WIDTH + 1 + PC_W;
`else
    localparam int SKID_W = DATA_WIDTH + 1;
`endif

    logic                     r_stall;
    logic [HSSIM_LATENCY-1:0] r_dl_vld;
    logic [DATA_WIDTH-1:0]    r_dl_old [HSSIM_LATENCY];
    logic [DATA_WIDTH-1:0]    r_dl_new [HSSIM_LATENCY];
    logic                     w_last_vld;
    logic                     w_pre_last_vld;
    logic                     w_last_vld_nxt;
    logic [DATA_WIDTH-1:0]    w_fused;
    logic                     w_push;
    logic                     w_hs;
    logic                     w_tag_last;
    logic [IDX_W-1:0]         r_push_idx;
    logic [SKID_W-1:0]        w_skid_din;
    logic [SKID_W-1:0]        w_skid_dout;
    logic [1:0]               w_occ;
    logic [1:0]               w_occ_nxt;
    logic                     r_frame_done;

    // ------------------------------------------------------------------
    // Delay line: valid bits are reset, pixel payload is not.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_dl_vld <= '0;
        end else if (!r_stall) begin
            r_dl_vld[0] <= s_valid;
            for (int k = 1; k < HSSIM_LATENCY; k++) begin
                r_dl_vld[k] <= r_dl_vld[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!r_stall) begin
            r_dl_old[0] <= s_old_pix;
            r_dl_new[0] <= s_new_pix;
            for (int k = 1; k < HSSIM_LATENCY; k++) begin
                r_dl_old[k] <= r_dl_old[k-1];
                r_dl_new[k] <= r_dl_new[k-1];
            end
        end
    end

    assign w_last_vld = r_dl_vld[HSSIM_LATENCY-1];

    // Valid bit that will sit in the last stage after this edge; used to
    // anticipate a push into a buffer that cannot drain.
    if (HSSIM_LATENCY > 1) begin : g_lat_multi
        assign w_pre_last_vld = r_dl_vld[HSSIM_LATENCY-2];
    end else begin : g_lat_single
        assign w_pre_last_vld = s_valid;
    end
    assign w_last_vld_nxt = r_stall ? w_last_vld : w_pre_last_vld;

    // ------------------------------------------------------------------
    // Per-pixel select at the last stage.
    // ------------------------------------------------------------------
    for (genvar j = 0; j < PIXELS_PER_BEAT; j++) begin : g_pix
        assign w_fused[j*8 +: 8] = (del[j*8 +: 8] == DEL_SELECT_NEW)
                                 ? r_dl_new[HSSIM_LATENCY-1][j*8 +: 8]
                                 : r_dl_old[HSSIM_LATENCY-1][j*8 +: 8];
    end

    assign w_push     = !r_stall && w_last_vld;
    assign w_hs       = m_valid && m_ready;
    // Beats are tagged on entry; FIFO order makes the push index equal to
    // the index the beat has when it is presented downstream.
    assign w_tag_last = (r_push_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_push_idx <= '0;
        end else if (w_push) begin
            r_push_idx <= w_tag_last ? '0 : r_push_idx + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output skid buffer
    // ------------------------------------------------------------------
`ifdef HSSIM_FUSE_STATS_EN
    logic [PC_W-1:0]  w_pc_in;
    logic [PC_W-1:0]  w_pc_out;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_new_count;

    always_comb begin
        w_pc_in = '0;
        for (int j = 0; j < PIXELS_PER_BEAT; j++) begin
            if (del[j*8 +: 8] == DEL_SELECT_NEW) begin
                w_pc_in = w_pc_in + PC_W'(1);
            end
        end
    end

    // The per-beat count rides along with the beat so it is accumulated
    // at the output handshake, not at capture.
    assign w_skid_din = {w_pc_in, w_tag_last, w_fused};
    assign w_pc_out   = w_skid_dout[DATA_WIDTH+1 +: PC_W];

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_acc       <= '0;
            r_new_count <= '0;
        end else if (w_hs) begin
            if (m_last) begin
                r_new_count <= r_acc + CNT_W'(w_pc_out);
                r_acc       <= '0;
            end else begin
                r_acc <= r_acc + CNT_W'(w_pc_out);
            end
        end
    end

    assign new_count = r_new_count;
`else
    assign w_skid_din = {w_tag_last, w_fused};
`endif

    lrf_skid_buf #(
        .WIDTH (SKID_W)
    ) u_skid (
        .clk     (clk),
        .aresetn (aresetn),
        .i_push  (w_push),
        .i_din   (w_skid_din),
        .i_ready (m_ready),
        .o_valid (m_valid),
        .o_dout  (w_skid_dout),
        .o_occ   (w_occ)
    );

    assign m_data = w_skid_dout[DATA_WIDTH-1:0];
    assign m_last = w_skid_dout[DATA_WIDTH];

    // ------------------------------------------------------------------
    // Stall: registered from next-cycle occupancy. A full buffer always
    // stalls; a single held entry stalls early when a beat is about to
    // reach the last stage and the consumer is not draining.
    // ------------------------------------------------------------------
    always_comb begin
        w_occ_nxt = w_occ;
        if (w_push && !w_hs) begin
            w_occ_nxt = w_occ + 2'd1;
        end else if (!w_push && w_hs) begin
            w_occ_nxt = w_occ - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_stall <= 1'b0;
        end else begin
            r_stall <= (w_occ_nxt == 2'd2)
                    || ((w_occ_nxt == 2'd1) && !m_ready && w_last_vld_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_hs && m_last;
        end
    end

    assign stall      = r_stall;
    assign s_ready    = !r_stall;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_hssim_fuse.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hssim_fuse
//  Purpose  : Self-checking bench for hssim_fuse at IMAGE_DIM=64 (256 beats
//             per frame). The bench also plays the HSSIM role, returning the
//             `del` map for each accepted beat after HSSIM_LATENCY enabled
//             cycles. Expected output is a queue of fused beats built from
//             the accepted inputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hssim_fuse;

    localparam int PPB = 16;
    localparam int DIM = 64;
    localparam int LAT = 10;
    localparam int DW  = 8 * PPB;
    localparam int BPF = DIM * DIM / PPB;
    localparam logic [DW-1:0] LIT_FUSED = 128'h1111EE1111EE1111EE1111EE1111EE11;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_old_pix = '0;
    logic [DW-1:0] s_new_pix = '0;
    logic [DW-1:0] del = '0;
    logic          stall;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          frame_done;
`ifdef HSSIM_FUSE_STATS_EN
    logic [$clog2(DIM*DIM):0] new_count;
`endif

    hssim_fuse #(
        .PIXELS_PER_BEAT (PPB),
        .IMAGE_DIM       (DIM),
        .HSSIM_LATENCY   (LAT)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_old_pix  (s_old_pix),
        .s_new_pix  (s_new_pix),
        .del        (del),
        .stall      (stall),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .frame_done (frame_done)
`ifdef HSSIM_FUSE_STATS_EN
        ,
        .new_count  (new_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    typedef struct {
        logic [DW-1:0] data;
        bit            lit;
        int            npop;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   out_idx = 0;
    int   hs_since_rst = 0;
    int   first_last_hs = -1;
    int   fd_cnt = 0;
    int   last_cnt = 0;
    int   acc_cyc = -1;
    int   mv_cyc = -1;
    bit   exp_fd = 1'b0;
    bit   chk_rst = 1'b0;
    int   stat_acc = 0;
    int   stat_total = 0;

    // ---------------- stimulus state ----------------
    logic [DW-1:0] hs_del [LAT];
    logic [DW-1:0] cur_del = '0;
    bit            cur_lit = 1'b0;
    int            vld_mode = 2;   // 0 continuous, 1 one-on/two-off, 2 idle
    int            del_mode = 0;   // 0 all 255, 1 fixed literal pattern, 2 random mix
    int            rdy_mode = 0;   // 0 high, 1 low, 2 random
    int            gcnt = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic logic [DW-1:0] fuse(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                           input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int j = 0; j < PPB; j++) begin
            r[j*8 +: 8] = (d[j*8 +: 8] == 8'd255) ? n[j*8 +: 8] : o[j*8 +: 8];
        end
        return r;
    endfunction

    function automatic int count_new(input logic [DW-1:0] d);
        int c = 0;
        for (int j = 0; j < PPB; j++) begin
            if (d[j*8 +: 8] == 8'd255) c++;
        end
        return c;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!aresetn) begin
            exp_q.delete();
            out_idx      = 0;
            hs_since_rst = 0;
            first_last_hs = -1;
            exp_fd       = 1'b0;
            chk_rst      = 1'b1;
            stat_acc     = 0;
        end else begin
            if (chk_rst) begin
                chk("rst_m_valid", m_valid, 0);
                chk("rst_m_last", m_last, 0);
                chk("rst_m_data", m_data, 0);
                chk("rst_stall", stall, 0);
                chk_rst = 1'b0;
            end
            chk("s_ready", s_ready, !stall);
            chk("frame_done", frame_done, exp_fd);
`ifdef HSSIM_FUSE_STATS_EN
            if (exp_fd) chk("new_count", new_count, stat_total);
`endif
            if (frame_done) fd_cnt++;
            exp_fd = 1'b0;

            if (m_valid) begin
                if (mv_cyc < 0) mv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    fail_now("spurious_beat");
                end else begin
                    chk("m_data", m_data, exp_q[0].data);
                    chk("m_last", m_last, out_idx == BPF - 1);
                    if (m_ready) begin
                        e = exp_q.pop_front();
                        if (e.lit) chk("literal_fused", m_data, LIT_FUSED);
                        stat_acc += e.npop;
                        if (out_idx == BPF - 1) begin
                            exp_fd     = 1'b1;
                            stat_total = stat_acc;
                            stat_acc   = 0;
                            out_idx    = 0;
                        end else begin
                            out_idx++;
                        end
                        if (m_last) begin
                            last_cnt++;
                            if (first_last_hs < 0) first_last_hs = hs_since_rst;
                        end
                        hs_since_rst++;
                    end
                end
            end

            if (s_valid && s_ready) begin
                e.data = fuse(s_old_pix, s_new_pix, cur_del);
                e.lit  = cur_lit;
                e.npop = count_new(cur_del);
                exp_q.push_back(e);
                if (acc_cyc < 0) acc_cyc = cyc;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic new_beat();
        case (vld_mode)
            0:       s_valid = 1'b1;
            1: begin
                s_valid = (gcnt == 0);
                gcnt    = (gcnt + 1) % 3;
            end
            default: s_valid = 1'b0;
        endcase
        cur_lit = (del_mode == 1);
        for (int j = 0; j < PPB; j++) begin
            if (del_mode == 1) begin
                s_old_pix[j*8 +: 8] = 8'h11;
                s_new_pix[j*8 +: 8] = 8'hEE;
                cur_del[j*8 +: 8]   = (j % 3 == 0) ? 8'h00 : (j % 3 == 1) ? 8'hFF : 8'h7F;
            end else begin
                s_old_pix[j*8 +: 8] = 8'($urandom);
                s_new_pix[j*8 +: 8] = 8'($urandom);
                if (del_mode == 0) begin
                    cur_del[j*8 +: 8] = 8'hFF;
                end else begin
                    case ($urandom_range(0, 3))
                        0:       cur_del[j*8 +: 8] = 8'h00;
                        1:       cur_del[j*8 +: 8] = 8'hFF;
                        2:       cur_del[j*8 +: 8] = 8'h7F;
                        default: cur_del[j*8 +: 8] = 8'($urandom);
                    endcase
                end
            end
        end
    endtask

    // One clock: observe handshake state at negedge, update inputs 1 time
    // unit after the rising edge.
    task automatic step();
        bit acc;
        bit adv;
        @(negedge clk);
        acc = s_valid && s_ready && aresetn;
        adv = !stall;
        @(posedge clk);
        #1;
        if (adv) begin
            for (int k = LAT - 1; k > 0; k--) hs_del[k] = hs_del[k-1];
            hs_del[0] = cur_del;
        end
        del = hs_del[LAT-1];
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (!s_valid || acc) new_beat();
    endtask

    initial begin
        bit done;
        for (int k = 0; k < LAT; k++) hs_del[k] = '0;

        // Reset, then continuous stream with del all 255.
        repeat (3) step();
        aresetn  = 1'b1;
        vld_mode = 0;
        del_mode = 0;
        rdy_mode = 0;
        m_ready  = 1'b1;
        new_beat();
        repeat (40) step();
        chk("first_latency", mv_cyc - acc_cyc, 11);

        // Fixed pattern: bytes 00/FF/7F -> old/new/old.
        del_mode = 1;
        repeat (20) step();

        // Random del mix with a 20-cycle back-pressure window.
        del_mode = 2;
        repeat (10) step();
        rdy_mode = 1;
        repeat (20) step();
        chk("stall_backpressure", stall, 1);
        chk("s_ready_backpressure", s_ready, 0);
        chk("m_valid_backpressure", m_valid, 1);
        rdy_mode = 2;
        repeat (60) step();

        // Input gaps: one beat on, two off.
        vld_mode = 1;
        rdy_mode = 0;
        repeat (60) step();
        rdy_mode = 2;
        repeat (60) step();

        // Run through two full frames.
        vld_mode = 0;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            step();
            if (fd_cnt >= 2) done = 1'b1;
        end
        if (!done) fail_now("two_frames");
        chk("first_m_last_index", first_last_hs, 255);
        chk("frame_done_per_last", fd_cnt, last_cnt);

        // Reset when 100 beats of the current frame have gone out.
        done = 1'b0;
        for (int i = 0; i < 1500 && !done; i++) begin
            step();
            if (out_idx == 100) done = 1'b1;
        end
        if (!done) fail_now("reach_beat_100");
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            step();
            if (first_last_hs >= 0) done = 1'b1;
        end
        if (!done) fail_now("last_after_reset");
        chk("m_last_after_reset", first_last_hs, 255);

        // Drain.
        vld_mode = 2;
        rdy_mode = 0;
        repeat (40) step();
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_m_valid", m_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
